// File: rtl/llc_rst_flush_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// llc_rst_flush_ctrl_pkg
//   Shared constants and types for the LLC reset/flush sweep controller.
//   - LLC_SETS / LLC_SET_W : default number of sets and the set-index width
//   - sweep_state_e        : controller state encoding
//   - state_counts_acks()  : states in which a set_ack advances the ack count
// -----------------------------------------------------------------------------
`ifndef LLC_SETS
`define LLC_SETS 16
`endif

package llc_rst_flush_ctrl_pkg;

    localparam int unsigned LLC_SETS  = `LLC_SETS;
    localparam int unsigned LLC_SET_W = $clog2(LLC_SETS);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RST_SWEEP   = 3'd1,
        ST_FLUSH_SWEEP = 3'd2,
        ST_DRAIN       = 3'd3,
        ST_DONE        = 3'd4
    } sweep_state_e;

    // Acks are only meaningful while sets can still be outstanding.
    function automatic logic state_counts_acks(input sweep_state_e s);
        return (s == ST_RST_SWEEP) || (s == ST_FLUSH_SWEEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/llc_rst_flush_ctrl_if.sv
// -----------------------------------------------------------------------------
// llc_rst_flush_ctrl_if
//   Sweep bus between the reset/flush controller and the cache pipeline.
//   master (controller): drives sweep_valid, sweep_set, sweep_is_rst,
//                        sweep_is_flush, llc_rst_tb_done_valid
//   slave  (pipeline)  : drives sweep_ready, set_ack, llc_rst_tb_done_ready
// -----------------------------------------------------------------------------
interface llc_rst_flush_ctrl_if
    import llc_rst_flush_ctrl_pkg::*;
#(
    parameter int unsigned SET_W = LLC_SET_W
);

    logic             sweep_valid;
    logic             sweep_ready;
    logic [SET_W-1:0] sweep_set;
    logic             sweep_is_rst;
    logic             sweep_is_flush;
    logic             set_ack;
    logic             llc_rst_tb_done_valid;
    logic             llc_rst_tb_done_ready;

    modport master (
        output sweep_valid, sweep_set, sweep_is_rst, sweep_is_flush,
               llc_rst_tb_done_valid,
        input  sweep_ready, set_ack, llc_rst_tb_done_ready
    );

    modport slave (
        input  sweep_valid, sweep_set, sweep_is_rst, sweep_is_flush,
               llc_rst_tb_done_valid,
        output sweep_ready, set_ack, llc_rst_tb_done_ready
    );

endinterface

// File: rtl/llc_rst_flush_ctrl_sweep_counter.sv
// -----------------------------------------------------------------------------
// llc_sweep_counter
//   Issue/ack counter pair for one sweep. Both counters are SET_W+1 bits so
//   that the value NUM_SETS ("all done") is representable; neither wraps.
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset
//     clr           : zero both counters (sweep entry / abort); wins over inc
//     issue         : a set was transferred this cycle
//     ack           : a set_ack arrived this cycle (already state-qualified)
//     can_issue     : more sets remain and the outstanding window has room
//     all_issued    : issue count has reached NUM_SETS
//     all_acked_nxt : ack count will equal NUM_SETS after this edge
//     issue_set     : low bits of the issue count (next set to offer)
// -----------------------------------------------------------------------------
module llc_sweep_counter #(
    parameter  int unsigned NUM_SETS        = 16,
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned SET_W           = $clog2(NUM_SETS),
    localparam int unsigned CNT_W           = SET_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             issue,
    input  logic             ack,
    output logic             can_issue,
    output logic             all_issued,
    output logic             all_acked_nxt,
    output logic [SET_W-1:0] issue_set
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SETS);

    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic [CNT_W-1:0] outstanding;
    logic             issue_inc;
    logic             ack_inc;

    always_comb begin
        outstanding = issue_cnt_q - ack_cnt_q;
        can_issue   = (issue_cnt_q != FULL) && (32'(outstanding) < MAX_OUTSTANDING);

        // Saturate at FULL; an ack with nothing outstanding is dropped.
        issue_inc = issue && (issue_cnt_q != FULL);
        ack_inc   = ack && (ack_cnt_q != issue_cnt_q);

        issue_cnt_d = issue_cnt_q + {{(CNT_W-1){1'b0}}, issue_inc};
        ack_cnt_d   = ack_cnt_q + {{(CNT_W-1){1'b0}}, ack_inc};
        if (clr) begin
            issue_cnt_d = '0;
            ack_cnt_d   = '0;
        end

        all_issued    = (issue_cnt_q == FULL);
        all_acked_nxt = (ack_cnt_d == FULL);
        issue_set     = issue_cnt_q[SET_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt_q <= '0;
            ack_cnt_q   <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
        end
    end

endmodule

// File: rtl/llc_rst_flush_ctrl.sv
// -----------------------------------------------------------------------------
// llc_rst_flush_ctrl
//   Sequences LLC reset and flush sweeps: offers every set index to the
//   pipeline in order, bounds the number of unacknowledged sets, waits for
//   all acks, then presents a done token.
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset
//     rst_start     : pulse, request a reset sweep (aborts a flush sweep)
//     flush_start   : pulse, request a flush sweep (latched if busy)
//     bus           : sweep offer/ack and done handshake (master side)
//     rst_stall     : reset sweep in progress (sweep, drain or done)
//     flush_stall   : flush sweep in progress (sweep, drain or done)
//     flush_pending : a flush request is latched and waiting
// -----------------------------------------------------------------------------
module llc_rst_flush_ctrl
    import llc_rst_flush_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SETS        = `LLC_SETS,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rst_start,
    input  logic                 flush_start,
    llc_rst_flush_ctrl_if.master bus,
    output logic                 rst_stall,
    output logic                 flush_stall,
    output logic                 flush_pending
);

    sweep_state_e state_q, state_d;
    // Remembers the sweep type once the state no longer encodes it (DRAIN/DONE).
    logic         is_rst_q, is_rst_d;
    logic         flush_pending_q, flush_pending_d;

    logic cnt_clr;
    logic cnt_issue;
    logic cnt_ack;
    logic can_issue;
    logic all_issued;
    logic all_acked_nxt;
    logic in_sweep;
    logic in_tail;

    llc_sweep_counter #(
        .NUM_SETS        (NUM_SETS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .clr           (cnt_clr),
        .issue         (cnt_issue),
        .ack           (cnt_ack),
        .can_issue     (can_issue),
        .all_issued    (all_issued),
        .all_acked_nxt (all_acked_nxt),
        .issue_set     (bus.sweep_set)
    );

    assign in_sweep  = (state_q == ST_RST_SWEEP) || (state_q == ST_FLUSH_SWEEP);
    assign in_tail   = (state_q == ST_DRAIN) || (state_q == ST_DONE);

    // valid depends only on registered state, so it cannot drop or change set
    // before the transfer: issue_cnt only moves on a transfer and acks only
    // widen the window.
    assign bus.sweep_valid           = in_sweep && can_issue;
    assign bus.sweep_is_rst          = (state_q == ST_RST_SWEEP);
    assign bus.sweep_is_flush        = (state_q == ST_FLUSH_SWEEP);
    assign bus.llc_rst_tb_done_valid = (state_q == ST_DONE);

    assign rst_stall     = (state_q == ST_RST_SWEEP) || (in_tail && is_rst_q);
    assign flush_stall   = (state_q == ST_FLUSH_SWEEP) || (in_tail && !is_rst_q);
    assign flush_pending = flush_pending_q;

    assign cnt_issue = bus.sweep_valid && bus.sweep_ready;
    assign cnt_ack   = bus.set_ack && state_counts_acks(state_q);

    always_comb begin
        state_d         = state_q;
        is_rst_d        = is_rst_q;
        flush_pending_d = flush_pending_q;
        cnt_clr         = 1'b0;

        // A flush that cannot start right now is remembered; this includes
        // a flush arriving together with a reset request in IDLE.
        if (flush_start && ((state_q != ST_IDLE) || rst_start)) begin
            flush_pending_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rst_start) begin
                    state_d  = ST_RST_SWEEP;
                    is_rst_d = 1'b1;
                    cnt_clr  = 1'b1;
                end else if (flush_start || flush_pending_q) begin
                    state_d         = ST_FLUSH_SWEEP;
                    is_rst_d        = 1'b0;
                    cnt_clr         = 1'b1;
                    flush_pending_d = 1'b0;
                end
            end

            ST_RST_SWEEP: begin
                if (all_issued) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_FLUSH_SWEEP: begin
                if (rst_start) begin
                    // Abort: the flush restarts from scratch after the reset.
                    state_d         = ST_RST_SWEEP;
                    is_rst_d        = 1'b1;
                    cnt_clr         = 1'b1;
                    flush_pending_d = 1'b1;
                end else if (all_issued) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (rst_start && !is_rst_q) begin
                    state_d         = ST_RST_SWEEP;
                    is_rst_d        = 1'b1;
                    cnt_clr         = 1'b1;
                    flush_pending_d = 1'b1;
                end else if (all_acked_nxt) begin
                    // Looks at the post-ack count so the final ack's own
                    // cycle already moves us to DONE.
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.llc_rst_tb_done_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            is_rst_q        <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            is_rst_q        <= is_rst_d;
            flush_pending_q <= flush_pending_d;
        end
    end

endmodule

// File: tb/tb_llc_rst_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_llc_rst_flush_ctrl
//   Directed + randomized bench for llc_rst_flush_ctrl (NUM_SETS=8,
//   MAX_OUTSTANDING=4). A behavioural model tracks the sweep phase, the next
//   set to hand out and a queue of outstanding set numbers; every cycle the
//   DUT outputs are compared with what that model expects.
// -----------------------------------------------------------------------------
module tb_llc_rst_flush_ctrl;
    import llc_rst_flush_ctrl_pkg::*;

    localparam int N    = 8;
    localparam int MAXO = 4;
    localparam int SW   = 3;

    // model phases
    localparam int PH_IDLE  = 0;
    localparam int PH_SWEEP = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_start = 1'b0;
    logic flush_start = 1'b0;
    logic rst_stall, flush_stall, flush_pending;

    llc_rst_flush_ctrl_if #(.SET_W(SW)) bus ();

    llc_rst_flush_ctrl #(
        .NUM_SETS        (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rst_start     (rst_start),
        .flush_start   (flush_start),
        .bus           (bus),
        .rst_stall     (rst_stall),
        .flush_stall   (flush_stall),
        .flush_pending (flush_pending)
    );

    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // behavioural model state
    int m_phase;
    bit m_rst_kind;
    bit m_pend;
    int m_next;
    int oq[$];        // sets issued but not yet acknowledged
    int ack_due[$];   // cycle numbers at which the pipeline returns an ack
    int cyc;
    int done_wait_cnt;

    // stimulus knobs
    int ready_mode;   // 0 always, 1 toggle, 2 random, 3 never
    int ack_lo, ack_hi;
    int done_wait_cfg;
    bit spur_ack;
    bit inject;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_rst_kind = 1'b0;
        m_pend = 1'b0;
        m_next = 0;
        oq.delete();
        ack_due.delete();
        done_wait_cnt = 0;
    endtask

    task automatic model_start(input bit kind);
        m_phase = PH_SWEEP;
        m_rst_kind = kind;
        m_next = 0;
        oq.delete();
        ack_due.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},   32'(bus.sweep_valid), 0);
        chk({tag, "_set"},     32'(bus.sweep_set), 0);
        chk({tag, "_is_rst"},  32'(bus.sweep_is_rst), 0);
        chk({tag, "_is_fl"},   32'(bus.sweep_is_flush), 0);
        chk({tag, "_done"},    32'(bus.llc_rst_tb_done_valid), 0);
        chk({tag, "_rstall"},  32'(rst_stall), 0);
        chk({tag, "_fstall"},  32'(flush_stall), 0);
        chk({tag, "_pending"}, 32'(flush_pending), 0);
    endtask

    // One clock cycle: called just after a falling edge; drives inputs,
    // checks outputs against the model, advances the model across the edge.
    task automatic tick(input bit rs, input bit fs);
        bit exp_valid, rdy, ack, drdy, xfer, ack_ok;
        int old_next;
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 2) == 0);
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b0;
        endcase
        ack = spur_ack;
        if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
            ack = 1'b1;
            void'(ack_due.pop_front());
        end
        drdy = (m_phase == PH_DONE) && (done_wait_cnt >= done_wait_cfg);

        rst_start = rs;
        flush_start = fs;
        bus.sweep_ready = rdy;
        bus.set_ack = ack;
        bus.llc_rst_tb_done_ready = drdy;
        #1;

        exp_valid = (m_phase == PH_SWEEP) && (m_next < N) && (oq.size() < MAXO);
        chk("sweep_valid", 32'(bus.sweep_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("sweep_set", 32'(bus.sweep_set), 32'(m_next));
            chk("sweep_is_rst", 32'(bus.sweep_is_rst), 32'(m_rst_kind));
            chk("sweep_is_flush", 32'(bus.sweep_is_flush), 32'(!m_rst_kind));
        end
        chk("rst_stall", 32'(rst_stall), 32'(m_phase != PH_IDLE && m_rst_kind));
        chk("flush_stall", 32'(flush_stall), 32'(m_phase != PH_IDLE && !m_rst_kind));
        chk("done_valid", 32'(bus.llc_rst_tb_done_valid), 32'(m_phase == PH_DONE));
        chk("flush_pending", 32'(flush_pending), 32'(m_pend));

        xfer = exp_valid && rdy;
        ack_ok = ack && (m_phase == PH_SWEEP || m_phase == PH_DRAIN) && (oq.size() > 0);
        old_next = m_next;
        if (fs && (m_phase != PH_IDLE || rs)) m_pend = 1'b1;

        case (m_phase)
            PH_IDLE: begin
                if (rs) model_start(1'b1);
                else if (fs || m_pend) begin
                    model_start(1'b0);
                    m_pend = 1'b0;
                end
            end
            PH_SWEEP, PH_DRAIN: begin
                if (rs && !m_rst_kind) begin
                    model_start(1'b1);
                    m_pend = 1'b1;
                end else begin
                    if (ack_ok) void'(oq.pop_front());
                    if (xfer) begin
                        oq.push_back(m_next);
                        m_next++;
                        ack_due.push_back(cyc + int'($urandom_range(ack_lo, ack_hi)));
                    end
                    if (m_phase == PH_SWEEP) begin
                        if (old_next == N) m_phase = PH_DRAIN;
                    end else if (oq.size() == 0) begin
                        m_phase = PH_DONE;
                        done_wait_cnt = 0;
                    end
                end
            end
            default: begin
                if (drdy) m_phase = PH_IDLE;
                else done_wait_cnt++;
            end
        endcase

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        bit rs, fs;
        n = 0;
        while ((m_phase != PH_IDLE || m_pend) && n < max) begin
            rs = inject && ($urandom_range(0, 39) == 0);
            fs = inject && ($urandom_range(0, 39) == 0);
            tick(rs, fs);
            n++;
        end
        chk({tag, "_completes"}, 32'(m_phase == PH_IDLE && !m_pend), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_assert = 0;
        n_fail = 0;
        cyc = 0;
        model_reset();
        ready_mode = 0;
        ack_lo = 3;
        ack_hi = 3;
        done_wait_cfg = 0;
        spur_ack = 1'b0;
        inject = 1'b0;
        bus.sweep_ready = 1'b0;
        bus.set_ack = 1'b0;
        bus.llc_rst_tb_done_ready = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b0;
        #2 check_all_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Reset sweep, ready always, ack three cycles after each issue.
        tick(1'b1, 1'b0);
        run_idle("rst_sweep", 200);

        // Flush sweep, ready toggling, done ready held off for 5 cycles.
        ready_mode = 1;
        done_wait_cfg = 5;
        tick(1'b0, 1'b1);
        run_idle("flush_toggle", 300);

        // Reset and flush together: reset first, then the latched flush.
        ready_mode = 0;
        done_wait_cfg = 0;
        tick(1'b1, 1'b1);
        chk("both_pending", 32'(flush_pending), 1);
        run_idle("rst_then_flush", 400);

        // Reset request after three flush sets: abort and restart at set 0.
        tick(1'b0, 1'b1);
        n = 0;
        while (m_next < 3 && n < 50) begin
            tick(1'b0, 1'b0);
            n++;
        end
        tick(1'b1, 1'b0);
        chk("abort_set0", 32'(bus.sweep_set), 0);
        chk("abort_rst", 32'(bus.sweep_is_rst), 1);
        run_idle("abort", 400);

        // Asynchronous reset in the middle of a reset sweep's drain.
        tick(1'b1, 1'b1);
        n = 0;
        while (m_phase != PH_DRAIN && n < 100) begin
            tick(1'b0, 1'b0);
            n++;
        end
        chk("reach_drain", 32'(rst_stall && !bus.sweep_valid && flush_pending), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(1'b1, 1'b0);
        run_idle("post_rst_sweep", 200);

        // Spurious acks with nothing outstanding, idle and mid-sweep.
        spur_ack = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        ready_mode = 3;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        spur_ack = 1'b0;
        ready_mode = 2;
        ack_lo = 1;
        ack_hi = 6;
        run_idle("spurious", 400);

        // Randomized sweeps with deep ack latency and random request injection.
        inject = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ack_lo = 2;
            ack_hi = 9;
            done_wait_cfg = int'($urandom_range(0, 3));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_idle("random", 800);
        end
        inject = 1'b0;
        tick(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/llc_rst_flush_ctrl.md
LLC_RST_FLUSH_CTRL -- requirements
Module: llc_rst_flush_ctrl

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter NUM_SETS SHALL default to `LLC_SETS (power of two, >=4): number of sets swept.
REQ-003 Parameter MAX_OUTSTANDING SHALL default to 4: maximum number of issued, unacknowledged sets.
REQ-004 clk  in  1  block clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 rst_start  in  1  one-cycle pulse; request a reset sweep.
REQ-007 flush_start  in  1  one-cycle pulse; request a flush sweep.
REQ-008 sweep_ready  in  1  the pipeline accepts a sweep set this cycle.
REQ-009 set_ack  in  1  pulse from the update stage (incr_rst_flush_stalled_set): one swept set written.
REQ-010 llc_rst_tb_done_ready  in  1  consumer ready for the done token.
REQ-011 sweep_valid  out  1  a sweep set is offered to the pipeline.
REQ-012 sweep_set  out  log2(NUM_SETS)  set index offered.
REQ-013 sweep_is_rst / sweep_is_flush  out  1 each  sweep type; exactly one is high while sweep_valid is high.
REQ-014 rst_stall / flush_stall  out  1 each  blocks normal request intake during the corresponding sweep.
REQ-015 llc_rst_tb_done_valid  out  1  sweep-complete token.
REQ-016 flush_pending  out  1  a flush is latched and waiting.

Function
REQ-017 The states SHALL be IDLE, RST_SWEEP, FLUSH_SWEEP, DRAIN and DONE.
REQ-018 IDLE: a rst_start pulse SHALL go to RST_SWEEP; otherwise a flush_start pulse or flush_pending SHALL go to FLUSH_SWEEP.
- Entry clears issue_cnt and ack_cnt.
- Flush entry clears flush_pending.
REQ-019 In either SWEEP state, sweep_valid SHALL be high when issue_cnt<NUM_SETS and outstanding<MAX_OUTSTANDING.
- outstanding = issue_cnt - ack_cnt.
REQ-020 A transfer SHALL occur when sweep_valid and sweep_ready are both high, and SHALL increment issue_cnt; sweep_set SHALL equal issue_cnt[log2(NUM_SETS)-1:0].
REQ-021 sweep_valid SHALL not drop and sweep_set SHALL not change until the transfer occurs.
REQ-022 set_ack SHALL increment ack_cnt in any state except IDLE and DONE; a simultaneous transfer and ack SHALL update both counters in the same cycle.
REQ-023 Both counters SHALL be log2(NUM_SETS)+1 bits wide and SHALL never wrap.
- A set_ack when ack_cnt==issue_cnt SHALL be ignored.
REQ-024 The SWEEP states SHALL go to DRAIN when issue_cnt==NUM_SETS.
REQ-025 DRAIN SHALL go to DONE when ack_cnt==NUM_SETS, including the cycle in which the final ack arrives.
REQ-026 DONE SHALL hold llc_rst_tb_done_valid high until llc_rst_tb_done_ready is high, then return to IDLE in the next cycle.
REQ-027 rst_stall SHALL be high in RST_SWEEP, and in DRAIN and DONE of a reset sweep; flush_stall SHALL be high in the corresponding flush states.
REQ-028 flush_start outside IDLE, or in the same cycle as rst_start, SHALL set flush_pending.
- The flush is serviced after the current sweep returns to IDLE.
REQ-029 rst_start during a flush sweep SHALL abort it at the next cycle boundary.
- Go to RST_SWEEP with counters cleared and flush_pending set.
- Unacked flush sets SHALL be discarded: ack_cnt is not incremented for them.
REQ-030 rst_start during a reset sweep SHALL be ignored.

Reset
REQ-031 Asserting rst SHALL asynchronously return the block to IDLE, including mid-sweep.
- issue_cnt, ack_cnt and flush_pending SHALL be 0.
- All outputs SHALL be 0.
REQ-032 After rst deasserts, the block SHALL accept rst_start on the first clock edge.

Structure
REQ-033 The state enum and `LLC_SETS / set-width constants SHALL live in the shared cache consts/types package.
REQ-034 The block SHALL have one natural sub-module, llc_sweep_counter: an issue/ack counter pair with outstanding compare, instantiated once.

Verification (bench NUM_SETS=8, MAX_OUTSTANDING=4)
REQ-035 rst_start, sweep_ready=1, set_ack 3 cycles after each issue -> sets 0..7 issued in order, never more than 4 outstanding, done_valid after the 8th ack, rst_stall high throughout.
REQ-036 Flush sweep with sweep_ready toggled 1/0 every cycle -> sweep_set stable while not accepted, 8 transfers, flush_stall high, done held until ready is asserted after 5 cycles.
REQ-037 rst_start and flush_start in the same cycle -> reset sweep first, flush_pending=1, then a flush sweep starts one cycle after the done handshake.
REQ-038 rst_start after 3 flush sets issued -> flush aborted, reset sweep restarts at set 0, flush_pending=1.
REQ-039 rst asserted asynchronously mid-DRAIN -> all outputs 0 with no clock edge; a later rst_start yields a full 8-set sweep.
REQ-040 Spurious set_ack with no outstanding sets -> ack_cnt unchanged, no early done.
